// File: rtl/aes_decipher_round.sv
// Purpose: one AES inverse round (init / main / final) on a 128-bit block, sharing four external inverse S-box ports across the columns.
// Latency: INIT result one cycle after accept; MAIN/FINAL result five cycles after accept (4 SUB + 1 MIX).
// Backpressure: ready low while busy; next is ignored (not queued) until ready returns high.
module aes_decipher_round #(
  parameter logic [1:0] INIT_ROUND  = 2'd0,
  parameter logic [1:0] MAIN_ROUND  = 2'd1,
  parameter logic [1:0] FINAL_ROUND = 2'd2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [1:0]   round_type,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [7:0]   isbox0_addr,
  output logic [7:0]   isbox1_addr,
  output logic [7:0]   isbox2_addr,
  output logic [7:0]   isbox3_addr,
  input  logic [7:0]   isbox0_data,
  input  logic [7:0]   isbox1_data,
  input  logic [7:0]   isbox2_data,
  input  logic [7:0]   isbox3_data,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    MIX  = 2'd2
  } fsm_t;

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [1:0]   type_reg;
  logic [1:0]   col_ctr;

  logic [31:0]  cur_col;
  logic [31:0]  sub_col;
  logic [127:0] sub_state;
  logic [127:0] add_state;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    mul09 = b8 ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    mul0b = b8 ^ b2 ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    mul0d = b8 ^ b4 ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    mul0e = b8 ^ b4 ^ b2;
  endfunction

  // One column of InvMixColumns; byte a0 is row 0 in the MSBs
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
    b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
    b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
    b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    inv_mix_col = {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    inv_mix_columns = {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                       inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) begin
      b[i] = s[127 - 8*i -: 8];
    end
    inv_shift_rows = {b[0],  b[13], b[10], b[7],
                      b[4],  b[1],  b[14], b[11],
                      b[8],  b[5],  b[2],  b[15],
                      b[12], b[9],  b[6],  b[3]};
  endfunction

  // Select the column under substitution and splice the S-box results back into it
  always_comb begin
    cur_col   = 32'h0;
    sub_col   = {isbox0_data, isbox1_data, isbox2_data, isbox3_data};
    sub_state = state_reg;
    case (col_ctr)
      2'd0: begin
        cur_col            = state_reg[127:96];
        sub_state[127:96]  = sub_col;
      end
      2'd1: begin
        cur_col            = state_reg[95:64];
        sub_state[95:64]   = sub_col;
      end
      2'd2: begin
        cur_col            = state_reg[63:32];
        sub_state[63:32]   = sub_col;
      end
      default: begin
        cur_col            = state_reg[31:0];
        sub_state[31:0]    = sub_col;
      end
    endcase
  end

  // S-box addresses are only driven during SUB so the shared S-box sees a quiet bus otherwise
  always_comb begin
    isbox0_addr = 8'h00;
    isbox1_addr = 8'h00;
    isbox2_addr = 8'h00;
    isbox3_addr = 8'h00;
    if (fsm == SUB) begin
      isbox0_addr = cur_col[31:24];
      isbox1_addr = cur_col[23:16];
      isbox2_addr = cur_col[15:8];
      isbox3_addr = cur_col[7:0];
    end
  end

  assign add_state = state_reg ^ key_reg;
  assign new_block = state_reg;
  assign ready     = (fsm == IDLE);

  // Round sequencer: accept in IDLE, four column substitutions, then key add / mix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      state_reg <= 128'h0;
      key_reg   <= 128'h0;
      type_reg  <= 2'd0;
      col_ctr   <= 2'd0;
    end else begin
      case (fsm)
        IDLE: begin
          if (next) begin
            case (round_type)
              INIT_ROUND: begin
                state_reg <= block ^ round_key;
              end
              MAIN_ROUND, FINAL_ROUND: begin
                state_reg <= inv_shift_rows(block);
                key_reg   <= round_key;
                type_reg  <= round_type;
                col_ctr   <= 2'd0;
                fsm       <= SUB;
              end
              default: begin
                // reserved encoding: request dropped
              end
            endcase
          end
        end
        SUB: begin
          state_reg <= sub_state;
          col_ctr   <= col_ctr + 2'd1;
          if (col_ctr == 2'd3) begin
            fsm <= MIX;
          end
        end
        MIX: begin
          if (type_reg == MAIN_ROUND) begin
            state_reg <= inv_mix_columns(add_state);
          end else begin
            state_reg <= add_state;
          end
          fsm <= IDLE;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_decipher_round.md
# aes_decipher_round

Iterative AES inverse-round datapath for the decipher side of the core. Each `next` applies one inverse round (initial AddRoundKey, main inverse round or final inverse round) to a 128-bit block under a supplied round key. The block drives four external inverse S-box lookup ports and time-multiplexes them over the four state columns, one column per cycle. It sits between the decipher control FSM (which sequences round keys and round types) and the shared inverse S-box instance.

## Interface
Parameters:
- `INIT_ROUND`, 2'd0: round type; AddRoundKey only.
- `MAIN_ROUND`, 2'd1: round type; InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
- `FINAL_ROUND`, 2'd2: round type; InvShiftRows, InvSubBytes, AddRoundKey.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `next`  in  1  start request; sampled only while `ready`=1.
- `round_type`  in  2  selects the operation; captured on accept.
- `round_key`  in  128  round key; captured on accept.
- `block`  in  128  input state; byte 0 = [127:120]; column-major, so byte 4c+r is row r, column c.
- `isbox0_addr`..`isbox3_addr`  out  8 each  inverse S-box addresses for rows 0..3 of the current column.
- `isbox0_data`..`isbox3_data`  in  8 each  inverse S-box results; combinational, same cycle.
- `new_block`  out  128  result; valid while `ready`=1.
- `ready`  out  1  high when idle and `new_block` holds a complete result.

## Operation
- Internal registers: `state_reg[127:0]`, `key_reg[127:0]`, `type_reg[1:0]`, `col_ctr[1:0]`, FSM in {IDLE, SUB, MIX}.
- `new_block` = `state_reg` continuously. `ready` = (FSM == IDLE).
- Accept happens when FSM is IDLE and `next`=1 at a rising edge:
  - INIT_ROUND: `state_reg` <= `block` ^ `round_key`; FSM stays in IDLE.
  - MAIN_ROUND or FINAL_ROUND: `state_reg` <= InvShiftRows(`block`); `key_reg`, `type_reg` captured; `col_ctr` <= 0; FSM -> SUB.
  - `round_type`=3: request ignored; no register changes.
- InvShiftRows moves row r right by r: out[r][c] = in[r][(c-r) mod 4].
- SUB (4 cycles):
  - `isboxR_addr` = `state_reg` byte (4*`col_ctr`+R).
  - On each edge those four bytes are replaced by `isboxR_data`, and `col_ctr` increments.
  - At `col_ctr`=3, FSM -> MIX.
- MIX (1 cycle): t = `state_reg` ^ `key_reg`.
  - MAIN_ROUND: `state_reg` <= InvMixColumns(t), per column matrix rows {0e,0b,0d,09} rotated; GF(2^8) multiply modulo 0x11b.
  - FINAL_ROUND: `state_reg` <= t.
  - FSM -> IDLE.
- Outside SUB, all `isbox*_addr` = 8'h00.
- `next` while busy is ignored and is not queued. If `next` is held high, a new round is accepted on the first IDLE edge.
- `block` and `round_key` may change after the accept edge without affecting the result.

## Timing
- Reset values:
  - FSM IDLE; `ready`=1.
  - `state_reg`, `key_reg` = 0, so `new_block`=128'h0.
  - `col_ctr`=0, `type_reg`=0, `isbox*_addr`=8'h00.
- Reset mid-operation aborts immediately: all registers return to reset values and no partial result is retained.
- INIT_ROUND: result visible one cycle after the accept edge; `ready` never drops.
- MAIN_ROUND and FINAL_ROUND, with accept at edge E0:
  - SUB covers columns 0..3 at edges E1..E4.
  - MIX at edge E5.
  - `ready` is low for exactly 5 cycles; high and `new_block` valid after E5.
- Back-to-back: `next` held high with a MAIN type gives one accept every 6 cycles.

## Test plan
- Reset asserted mid-SUB (after E2) -> within the same cycle `ready`=1, `new_block`=0, all addresses 0; a following MAIN round produces a correct result.
- INIT: `block`=69c4e0d86a7b0430d8cdb78070b4c55a, key=13111d7fe3944a17f307a78b4d2b30c5 -> next cycle `new_block`=7ad5fda789ef4e272bca100b3d9ff59f, `ready` stays 1.
- FINAL: `block`=6353e08c0960e104cd70b751bacad0e7, key=000102030405060708090a0b0c0d0e0f, bench inverse S-box -> `ready` low 5 cycles, then `new_block`=00112233445566778899aabbccddeeff.
- MAIN: `block` all 8'h52, key all 8'ha5 -> after 5 cycles `new_block` all 8'ha5. Also check the address sequence per column: all 8'h52.
- MAIN: `block`=7ad5fda789ef4e272bca100b3d9ff59f, key=549932d1f08557681093ed9cbe2c974e -> after E4 `state_reg`=bd6e7c3df2b5779e0b61216e8b10b689; final result matches the reference model (FIPS-197 C.1 round 2 istart).
- `next` pulsed during SUB, and `round_type`=3 with `next` in IDLE -> both ignored; timing and result are unchanged.
